seg_scan_driver: RTL and testbench



---
 rtl/display_pkg.sv | 32 +++
 rtl/seg_scan_driver_if.sv | 27 ++
 rtl/char_to_seg.sv | 50 +++++
 rtl/seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg_scan_driver.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared character codes, sizes and active-high segment patterns for the display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned CODE_W     = 6;
  localparam int unsigned PAT_W      = 7;

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] codes_t;

  localparam logic [CODE_W-1:0] CH_BLANK = 6'd10;
  localparam logic [CODE_W-1:0] CH_A = 6'd11, CH_B = 6'd12, CH_C = 6'd13, CH_D = 6'd14;
  localparam logic [CODE_W-1:0] CH_E = 6'd15, CH_F = 6'd16, CH_G = 6'd17, CH_H = 6'd18;
  localparam logic [CODE_W-1:0] CH_I = 6'd19, CH_J = 6'd20, CH_K = 6'd21, CH_L = 6'd22;
  localparam logic [CODE_W-1:0] CH_M = 6'd23, CH_N = 6'd24, CH_O = 6'd25, CH_P = 6'd26;
  localparam logic [CODE_W-1:0] CH_Q = 6'd27, CH_R = 6'd28, CH_S = 6'd29, CH_T = 6'd30;
  localparam logic [CODE_W-1:0] CH_U = 6'd31;
  localparam logic [CODE_W-1:0] CH_DASH = 6'd32;

  // Patterns are {g, f, e, d, c, b, a}, 1 = segment lit.
  localparam logic [PAT_W-1:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F;
  localparam logic [PAT_W-1:0] SEG_4 = 7'h66, SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07;
  localparam logic [PAT_W-1:0] SEG_8 = 7'h7F, SEG_9 = 7'h6F;
  localparam logic [PAT_W-1:0] SEG_A = 7'h77, SEG_B = 7'h7C, SEG_C = 7'h39, SEG_D = 7'h5E;
  localparam logic [PAT_W-1:0] SEG_E = 7'h79, SEG_F = 7'h71, SEG_G = 7'h3D, SEG_H = 7'h76;
  localparam logic [PAT_W-1:0] SEG_I = 7'h30, SEG_J = 7'h1E, SEG_K = 7'h75, SEG_L = 7'h38;
  localparam logic [PAT_W-1:0] SEG_M = 7'h37, SEG_N = 7'h54, SEG_O = 7'h5C, SEG_P = 7'h73;
  localparam logic [PAT_W-1:0] SEG_Q = 7'h67, SEG_R = 7'h50, SEG_S = 7'h6D, SEG_T = 7'h78;
  localparam logic [PAT_W-1:0] SEG_U = 7'h3E;
  localparam logic [PAT_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [PAT_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Content-side and board-side signals of the scan driver, grouped as one bus.
interface seg_scan_driver_if;
  import display_pkg::*;

  logic                  enable;
  logic [CODE_W-1:0]     data1;
  logic [CODE_W-1:0]     data2;
  logic [CODE_W-1:0]     data3;
  logic [CODE_W-1:0]     data4;
  logic [CODE_W-1:0]     data5;
  logic [CODE_W-1:0]     data6;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [PAT_W:0]        seg;
  logic [NUM_DIGITS-1:0] dig;
  logic                  frame_start;

  modport master (
    output enable, data1, data2, data3, data4, data5, data6, blink_mask,
    input  seg, dig, frame_start
  );

  modport slave (
    input  enable, data1, data2, data3, data4, data5, data6, blink_mask,
    output seg, dig, frame_start
  );

endinterface

// File: rtl/char_to_seg.sv
// Character code to active-high seven-segment pattern; unknown codes are blank.
module char_to_seg
  import display_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [PAT_W-1:0]  pat_c
);

  // Code lookup
  always_comb begin
    pat_c = SEG_BLANK;
    case (code_i)
      6'd0:     pat_c = SEG_0;
      6'd1:     pat_c = SEG_1;
      6'd2:     pat_c = SEG_2;
      6'd3:     pat_c = SEG_3;
      6'd4:     pat_c = SEG_4;
      6'd5:     pat_c = SEG_5;
      6'd6:     pat_c = SEG_6;
      6'd7:     pat_c = SEG_7;
      6'd8:     pat_c = SEG_8;
      6'd9:     pat_c = SEG_9;
      CH_BLANK: pat_c = SEG_BLANK;
      CH_A:     pat_c = SEG_A;
      CH_B:     pat_c = SEG_B;
      CH_C:     pat_c = SEG_C;
      CH_D:     pat_c = SEG_D;
      CH_E:     pat_c = SEG_E;
      CH_F:     pat_c = SEG_F;
      CH_G:     pat_c = SEG_G;
      CH_H:     pat_c = SEG_H;
      CH_I:     pat_c = SEG_I;
      CH_J:     pat_c = SEG_J;
      CH_K:     pat_c = SEG_K;
      CH_L:     pat_c = SEG_L;
      CH_M:     pat_c = SEG_M;
      CH_N:     pat_c = SEG_N;
      CH_O:     pat_c = SEG_O;
      CH_P:     pat_c = SEG_P;
      CH_Q:     pat_c = SEG_Q;
      CH_R:     pat_c = SEG_R;
      CH_S:     pat_c = SEG_S;
      CH_T:     pat_c = SEG_T;
      CH_U:     pat_c = SEG_U;
      CH_DASH:  pat_c = SEG_DASH;
      default:  pat_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver: per-frame snapshot, ghost gap, blinking.
module seg_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned DIV            = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned PCNT_W = $clog2(DIV);
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned SEG_W  = PAT_W + 1;
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  blink_ph_q, blink_ph_d;
  codes_t                snap_q, snap_d;
  logic [NUM_DIGITS-1:0] snap_mask_q, snap_mask_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  frame_start_q, frame_start_d;

  codes_t            live_c;
  logic              tick_c, wrap_c;
  logic [CODE_W-1:0] code_c;
  logic [PAT_W-1:0]  pat_c;
  logic [PAT_W-1:0]  lit_c;

  assign live_c = {bus.data6, bus.data5, bus.data4, bus.data3, bus.data2, bus.data1};
  assign tick_c = bus.enable && (pcnt_q == PCNT_W'(DIV - 1));
  assign wrap_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Scan counters, snapshot and blink phase; a low enable overrides any tick
  always_comb begin
    pcnt_d        = pcnt_q;
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    blink_ph_d    = blink_ph_q;
    snap_d        = snap_q;
    snap_mask_d   = snap_mask_q;
    frame_start_d = 1'b0;
    if (!bus.enable) begin
      pcnt_d      = '0;
      idx_d       = '0;
      fcnt_d      = '0;
      blink_ph_d  = 1'b0;
      snap_d      = live_c;
      snap_mask_d = bus.blink_mask;
    end else begin
      pcnt_d = tick_c ? '0 : pcnt_q + PCNT_W'(1);
      if (tick_c) begin
        idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
      end
      if (wrap_c) begin
        snap_d        = live_c;
        snap_mask_d   = bus.blink_mask;
        frame_start_d = 1'b1;
        if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
          fcnt_d     = '0;
          blink_ph_d = ~blink_ph_q;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
    end
  end

  // Decode the digit that will be current after this edge so seg leads dig by a cycle
  assign code_c = snap_d[idx_d];

  char_to_seg u_char_to_seg (
    .code_i (code_c),
    .pat_c  (pat_c)
  );

  // Output levels: XOR with the off level applies the pin polarity
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    lit_c = (snap_mask_d[idx_d] && blink_ph_d) ? SEG_BLANK : pat_c;
    if (bus.enable) begin
      seg_d = {1'b0, lit_c} ^ SEG_OFF;
      if (!tick_c) begin
        dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      blink_ph_q    <= 1'b0;
      snap_q        <= {NUM_DIGITS{CH_BLANK}};
      snap_mask_q   <= '0;
      seg_q         <= SEG_OFF;
      dig_q         <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      blink_ph_q    <= blink_ph_d;
      snap_q        <= snap_d;
      snap_mask_q   <= snap_mask_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dig         = dig_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with DIV=4, BLINK_FRAMES=2, active-low pins.
module tb_seg_scan_driver;

  localparam int unsigned DIV = 4;
  localparam int unsigned BF  = 2;
  localparam int unsigned NV  = 5;

  logic clk;
  logic rst_n;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .DIV            (DIV),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame of inputs and the unblanked active-low seg value expected per digit
  typedef struct {
    logic [5:0] code [6];
    logic [5:0] mask;
    logic [7:0] seg  [6];
  } vec_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] dig;
    logic       fs;
  } exp_t;

  vec_t tbl [NV];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] segv(input int e, input int k, input bit ph);
    return (tbl[e].mask[k] && ph) ? 8'hFF : tbl[e].seg[k];
  endfunction

  function automatic logic [5:0] digv(input int k);
    logic [5:0] one;
    one = 6'd1 << k;
    return 6'h3F ^ one;
  endfunction

  function automatic bit ph_of(input int n);
    return ((n / 2) % 2) == 1;
  endfunction

  // Expected samples for one frame: 3 lit cycles per digit then a dark cycle showing the next seg
  task automatic push_frame(input int e, input bit ph, input int en, input bit phn);
    exp_t x;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 3; r++) begin
        x.seg = segv(e, k, ph);
        x.dig = digv(k);
        x.fs  = 1'b0;
        sb.push_back(x);
      end
      x.seg = (k < 5) ? segv(e, k + 1, ph) : segv(en, 0, phn);
      x.dig = 6'h3F;
      x.fs  = (k == 5);
      sb.push_back(x);
    end
  endtask

  task automatic drive(input int e);
    bus.data1      = tbl[e].code[0];
    bus.data2      = tbl[e].code[1];
    bus.data3      = tbl[e].code[2];
    bus.data4      = tbl[e].code[3];
    bus.data5      = tbl[e].code[4];
    bus.data6      = tbl[e].code[5];
    bus.blink_mask = tbl[e].mask;
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard has 0 entries, expected at least 1", tag);
    end else begin
      x = sb.pop_front();
      check({tag, "_seg"}, bus.seg, x.seg);
      check({tag, "_dig"}, {2'b00, bus.dig}, {2'b00, x.dig});
      check({tag, "_fs"}, {7'd0, bus.frame_start}, {7'd0, x.fs});
    end
  endtask

  initial begin
    tbl[0].code = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};
    tbl[0].mask = 6'b000001;
    tbl[0].seg  = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    tbl[1].code = '{6'd1, 6'd2, 6'd7, 6'd4, 6'd5, 6'd6};
    tbl[1].mask = 6'b000001;
    tbl[1].seg  = '{8'hF9, 8'hA4, 8'hF8, 8'h99, 8'h92, 8'h82};
    tbl[2].code = '{6'd11, 6'd30, 6'd32, 6'd40, 6'd10, 6'd0};
    tbl[2].mask = 6'b000001;
    tbl[2].seg  = '{8'h88, 8'h87, 8'hBF, 8'hFF, 8'hFF, 8'hC0};
    tbl[3]      = tbl[2];
    tbl[4].code = '{6'd8, 6'd9, 6'd63, 6'd33, 6'd12, 6'd13};
    tbl[4].mask = 6'b000001;
    tbl[4].seg  = '{8'h80, 8'h90, 8'hFF, 8'hFF, 8'h83, 8'hC6};

    rst_n      = 1'b0;
    bus.enable = 1'b0;
    drive(0);
    repeat (2) @(negedge clk);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_dig", {2'b00, bus.dig}, 8'h3F);
    check("rst_fs", {7'd0, bus.frame_start}, 8'h00);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_seg", bus.seg, 8'hFF);
    check("idle_dig", {2'b00, bus.dig}, 8'h3F);

    // Table frames; next inputs land mid-frame while idx = 1
    bus.enable = 1'b1;
    for (int n = 0; n < NV; n++) begin
      push_frame(n, ph_of(n), (n < NV - 1) ? n + 1 : NV - 1, ph_of(n + 1));
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        pop_check($sformatf("f%0d_c%0d", n, c));
        if (c == 5 && n < NV - 1) drive(n + 1);
      end
    end

    // Enable drop while digit 3 is lit
    repeat (14) @(negedge clk);
    check("pre_drop_dig", {2'b00, bus.dig}, 8'h37);
    bus.enable = 1'b0;
    @(negedge clk);
    check("drop_dig", {2'b00, bus.dig}, 8'h3F);
    check("drop_seg", bus.seg, 8'hFF);
    check("drop_fs", {7'd0, bus.frame_start}, 8'h00);
    @(negedge clk);
    check("drop_dig2", {2'b00, bus.dig}, 8'h3F);

    // Re-enable restarts at idx 0; frame_start only at the 5->0 wrap
    bus.enable = 1'b1;
    push_frame(4, 1'b0, 4, 1'b0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      pop_check($sformatf("re_c%0d", c));
    end

    // Enable falls on the same edge as the wrapping tick
    repeat (23) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("tickfall_fs", {7'd0, bus.frame_start}, 8'h00);
    check("tickfall_dig", {2'b00, bus.dig}, 8'h3F);
    check("tickfall_seg", bus.seg, 8'hFF);
    @(negedge clk);
    check("tickfall_fs2", {7'd0, bus.frame_start}, 8'h00);

    // Asynchronous reset between clock edges
    bus.enable = 1'b1;
    @(negedge clk);
    check("prerst_dig", {2'b00, bus.dig}, 8'h3E);
    check("prerst_seg", bus.seg, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", bus.seg, 8'hFF);
    check("arst_dig", {2'b00, bus.dig}, 8'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_dig0", {2'b00, bus.dig}, 8'h3E);
    check("postrst_seg0", bus.seg, 8'hFF);
    repeat (3) @(negedge clk);
    check("postrst_gap", {2'b00, bus.dig}, 8'h3F);
    @(negedge clk);
    check("postrst_dig1", {2'b00, bus.dig}, 8'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
